cdc_2ch_arbiter: RTL
====================

# cdc_2ch_arbiter

Two-channel byte-stream arbiter/scheduler sitting between the two application channels of the USB CDC loopback design and a single shared downstream byte engine. Grants the shared sink to one channel at a time in bursts of up to MAX_BURST bytes, tags each forwarded byte with its channel number, and demultiplexes the tagged return stream back to the owning channel. Round-robin fairness by default; strict priority is a build option.

## Interface
- MAX_BURST, 8: maximum bytes forwarded per grant; legal range 1..255; matches bulk max packet size.
- clk_i  in  1  single clock; all logic on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- in0_data_i / in1_data_i  in  8  channel 0/1 request bytes.
- in0_valid_i / in1_valid_i  in  1  channel 0/1 byte valid.
- in0_ready_o / in1_ready_o  out  1  channel 0/1 byte accepted when valid & ready.
- out_data_o  out  8  byte to shared sink.
- out_ch_o  out  1  channel tag of out_data_o.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  shared sink accepts.
- ret_data_i  in  8  return byte from shared engine.
- ret_ch_i  in  1  channel tag of return byte.
- ret_valid_i  in  1  return byte valid.
- ret_ready_o  out  1  return byte accepted.
- ret0_data_o / ret1_data_o  out  8  demuxed return bytes.
- ret0_valid_o / ret1_valid_o  out  1  demuxed valids.
- ret0_ready_i / ret1_ready_i  in  1  channel 0/1 return sink ready.

## Operation
- Forward FSM states: IDLE, GRANT0, GRANT1. Register last_ch records last channel granted.
- IDLE: in0_ready_o = in1_ready_o = 0. If exactly one valid, grant it. If both valid, grant channel != last_ch. Transition takes effect next cycle.
- GRANTx: inx_ready_o = (!out_valid_o | out_ready_i); other ready = 0. Accepted byte loads out_data_o, out_ch_o = x, out_valid_o = 1; burst counter increments.
- Release from GRANTx when (a) a byte is accepted with count == MAX_BURST-1, or (b) inx_valid_i is low. On release, count clears, last_ch = x; next state = GRANT(other) if other valid, else IDLE. Case (b) with no accepted bytes still rotates.
- Output register: out_valid_o clears on out_ready_i with no new load; holds data/tag stable while out_valid_o & !out_ready_i.
- Return path: single register stage. Load when slot empty or selected sink drains it; retN_valid_o = slot_valid & (slot_ch == N); ret_ready_o = !slot_valid | (slot_ch ? ret1_ready_i : ret0_ready_i). A stalled channel blocks the return path (head-of-line) by design.
- Counter is 8 bits; never exceeds MAX_BURST-1.

## Timing
- Reset values: state IDLE, last_ch 1 (channel 0 wins first tie), count 0, out_valid_o 0, out_data_o 0, out_ch_o 0, ret slot empty, ret0/1_valid_o 0, ret data outputs 0, ret_ready_o 1 (combinational from empty slot), in ready outputs 0.
- Grant latency: valid rising in IDLE -> ready high next cycle.
- Forward latency: byte accepted at edge N -> out_valid_o high after edge N.
- Full throughput: 1 byte/cycle while out_ready_i held high; channel switch with other valid costs zero idle cycles.
- Return latency: 1 cycle; 1 byte/cycle when sink ready.
- Reset asserted mid-burst: all state returns to reset values immediately; in-flight output/return bytes discarded.

## Configuration
- ARB_STRICT_PRIO_EN: when defined, channel 0 always wins ties and, on any release from GRANT1, channel 0 is granted if in0_valid_i; last_ch unused. MAX_BURST still bounds GRANT1 bursts. When undefined, round-robin as above.

## Test plan
- Single channel: ch0 sends 01..07, out_ready_i=1 -> out_data_o 01..07, out_ch_o=0, one per cycle after 1-cycle grant.
- Both valid continuously, MAX_BURST=8, ch0 bytes 01.., ch1 bytes 81.. -> out sequence 8x ch0, 8x ch1, 8x ch0, no idle cycle between bursts.
- Backpressure: out_ready_i low 5 cycles mid-burst -> out_data_o/out_ch_o stable, in ready low, no byte lost or duplicated.
- Return demux: ret bytes 11 (ch0), 91 (ch1), 12 (ch0) with ret1_ready_i low 3 cycles -> ret0 gets 11, ret1 gets 91 after stall, ret0 gets 12 only after 91 drains.
- Reset mid-burst after 3 of 8 ch1 bytes -> outputs at reset values, next tie grants ch0.
- ARB_STRICT_PRIO_EN defined, both valid continuously -> ch1 never granted until in0_valid_i drops.

Source files
------------

// File: rtl/cdc_2ch_arbiter.sv
// Two-channel byte arbiter with burst grants, channel tagging and a tagged return demux.
// Build option ARB_STRICT_PRIO_EN: channel 0 strict priority instead of round-robin.
module cdc_2ch_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] in0_data_i,
    input  logic       in0_valid_i,
    output logic       in0_ready_o,
    input  logic [7:0] in1_data_i,
    input  logic       in1_valid_i,
    output logic       in1_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_ch_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    input  logic [7:0] ret_data_i,
    input  logic       ret_ch_i,
    input  logic       ret_valid_i,
    output logic       ret_ready_o,
    output logic [7:0] ret0_data_o,
    output logic       ret0_valid_o,
    input  logic       ret0_ready_i,
    output logic [7:0] ret1_data_o,
    output logic       ret1_valid_o,
    input  logic       ret1_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_ch_q, out_ch_d;
    logic       out_valid_q, out_valid_d;
    logic       out_free, acc0, acc1;

    logic [7:0] slot_data_q, slot_data_d;
    logic       slot_ch_q, slot_ch_d;
    logic       slot_valid_q, slot_valid_d;
    logic       slot_sink_rdy, ret_load;

`ifdef ARB_STRICT_PRIO_EN
    state_t prio_next;
    assign prio_next = in0_valid_i ? GRANT0 : (in1_valid_i ? GRANT1 : IDLE);
`else
    logic last_ch_q, last_ch_d;
`endif

    assign out_free    = !out_valid_q || out_ready_i;
    assign in0_ready_o = (state_q == GRANT0) && out_free;
    assign in1_ready_o = (state_q == GRANT1) && out_free;
    assign acc0        = in0_valid_i && in0_ready_o;
    assign acc1        = in1_valid_i && in1_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifndef ARB_STRICT_PRIO_EN
        last_ch_d = last_ch_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef ARB_STRICT_PRIO_EN
                state_d = prio_next;
`else
                if (in0_valid_i && in1_valid_i) state_d = last_ch_q ? GRANT0 : GRANT1;
                else if (in0_valid_i)           state_d = GRANT0;
                else if (in1_valid_i)           state_d = GRANT1;
`endif
            end
            GRANT0: begin
                if (acc0) cnt_d = cnt_q + 8'd1;
                // Release on a full burst or as soon as the granted channel goes idle.
                if (!in0_valid_i || (acc0 && cnt_q == LAST_CNT)) begin
                    cnt_d = '0;
`ifdef ARB_STRICT_PRIO_EN
                    state_d = prio_next;
`else
                    last_ch_d = 1'b0;
                    state_d   = in1_valid_i ? GRANT1 : IDLE;
`endif
                end
            end
            GRANT1: begin
                if (acc1) cnt_d = cnt_q + 8'd1;
                if (!in1_valid_i || (acc1 && cnt_q == LAST_CNT)) begin
                    cnt_d = '0;
`ifdef ARB_STRICT_PRIO_EN
                    state_d = prio_next;
`else
                    last_ch_d = 1'b1;
                    state_d   = in0_valid_i ? GRANT0 : IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (acc0) begin
            out_data_d  = in0_data_i;
            out_ch_d    = 1'b0;
            out_valid_d = 1'b1;
        end else if (acc1) begin
            out_data_d  = in1_data_i;
            out_ch_d    = 1'b1;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Single-entry return slot; a stalled owner blocks the other channel (head-of-line).
    assign slot_sink_rdy = slot_ch_q ? ret1_ready_i : ret0_ready_i;
    assign ret_ready_o   = !slot_valid_q || slot_sink_rdy;
    assign ret_load      = ret_valid_i && ret_ready_o;

    always_comb begin
        slot_data_d  = slot_data_q;
        slot_ch_d    = slot_ch_q;
        slot_valid_d = slot_valid_q;
        if (ret_load) begin
            slot_data_d  = ret_data_i;
            slot_ch_d    = ret_ch_i;
            slot_valid_d = 1'b1;
        end else if (slot_sink_rdy) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_ch_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            slot_data_q  <= '0;
            slot_ch_q    <= 1'b0;
            slot_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            slot_data_q  <= slot_data_d;
            slot_ch_q    <= slot_ch_d;
            slot_valid_q <= slot_valid_d;
        end
    end

`ifndef ARB_STRICT_PRIO_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) last_ch_q <= 1'b1;
        else         last_ch_q <= last_ch_d;
    end
`endif

    assign out_data_o   = out_data_q;
    assign out_ch_o     = out_ch_q;
    assign out_valid_o  = out_valid_q;
    assign ret0_data_o  = slot_data_q;
    assign ret1_data_o  = slot_data_q;
    assign ret0_valid_o = slot_valid_q && !slot_ch_q;
    assign ret1_valid_o = slot_valid_q && slot_ch_q;

endmodule
